// File: rtl/scale_agc_if.sv
// scale_agc_if: signal bundle between the AGC and its environment.
//   in_valid, in          : sample stream (same samples that feed scaler_down)
//   cfg_win_len           : window length minus 1, in valid samples
//   cfg_manual            : 1 = software-forced shift, 0 = automatic
//   cfg_manual_scale      : shift used in manual mode
//   scale, scale_upd      : shift to the scaler, one-cycle change pulse (auto mode)
//   peak_out              : peak magnitude of the last completed window
// Modports: slave = AGC side, master = environment side.
interface scale_agc_if #(
    parameter int IN_WIDTH    = 16,
    parameter int SCALE_WIDTH = 4,
    parameter int WIN_WIDTH   = 16
);
    logic                   in_valid;
    logic [IN_WIDTH-1:0]    in;
    logic [WIN_WIDTH-1:0]   cfg_win_len;
    logic                   cfg_manual;
    logic [SCALE_WIDTH-1:0] cfg_manual_scale;
    logic [SCALE_WIDTH-1:0] scale;
    logic                   scale_upd;
    logic [IN_WIDTH-2:0]    peak_out;

    modport slave (
        input  in_valid, in, cfg_win_len, cfg_manual, cfg_manual_scale,
        output scale, scale_upd, peak_out
    );

    modport master (
        output in_valid, in, cfg_win_len, cfg_manual, cfg_manual_scale,
        input  scale, scale_upd, peak_out
    );
endinterface

// File: rtl/scale_agc.sv
// scale_agc: automatic gain control for the scaler_down bit-width reduction.
// Tracks the peak magnitude over a window of valid samples, then derives the
// right-shift that keeps the reduced output within OUT_WIDTH signed bits.
// Attack is immediate, release is one step per window. Manual mode forces
// the shift each cycle while measurement continues.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : scale_agc_if.slave (sample stream, config, scale/scale_upd/peak_out)
module scale_agc #(
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 4,
    parameter int SCALE_WIDTH = 4,
    parameter int WIN_WIDTH   = 16
) (
    input logic        clk,
    input logic        reset,
    scale_agc_if.slave bus
);

    localparam int unsigned SHIFT_FIELD = (2 ** SCALE_WIDTH) - 1;
    localparam int unsigned HEADROOM    = IN_WIDTH - OUT_WIDTH;
    localparam int unsigned MAX_SHIFT   = (SHIFT_FIELD < HEADROOM) ? SHIFT_FIELD : HEADROOM;
    localparam int unsigned MAG_W       = IN_WIDTH - 1;
    localparam int unsigned OUT_MAG_W   = OUT_WIDTH - 1;
    localparam logic [SCALE_WIDTH-1:0] MAX_SCALE = SCALE_WIDTH'(MAX_SHIFT);

    typedef enum logic [1:0] {MEASURE, DECIDE, APPLY} state_t;

    state_t                 state_q, state_d;
    logic [IN_WIDTH-2:0]    peak_q, peak_d;
    logic [WIN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIN_WIDTH-1:0]   win_len_q, win_len_d;
    logic [SCALE_WIDTH-1:0] target_q, target_d;
    logic [SCALE_WIDTH-1:0] scale_q, scale_d;
    logic                   scale_upd_q, scale_upd_d;
    logic [IN_WIDTH-2:0]    peak_out_q, peak_out_d;

    logic [IN_WIDTH-2:0]    mag;
    logic [SCALE_WIDTH-1:0] target_calc;
    logic [SCALE_WIDTH-1:0] manual_scale;
    int unsigned            bl;
    int unsigned            shift;

    // One's complement magnitude: the most negative input maps to the
    // largest positive magnitude without needing an extra bit.
    always_comb begin
        mag = bus.in[IN_WIDTH-1] ? ~bus.in[IN_WIDTH-2:0] : bus.in[IN_WIDTH-2:0];
    end

    // Bit length of the window peak, converted to the clamped shift.
    always_comb begin
        bl = 0;
        for (int unsigned i = 0; i < MAG_W; i++) begin
            if (peak_q[i]) bl = i + 1;
        end
        shift = (bl > OUT_MAG_W) ? (bl - OUT_MAG_W) : 0;
        if (shift > MAX_SHIFT) shift = MAX_SHIFT;
        target_calc = shift[SCALE_WIDTH-1:0];
    end

    always_comb begin
        manual_scale = (bus.cfg_manual_scale > MAX_SCALE) ? MAX_SCALE : bus.cfg_manual_scale;
    end

    always_comb begin
        state_d     = state_q;
        peak_d      = peak_q;
        cnt_d       = cnt_q;
        win_len_d   = win_len_q;
        target_d    = target_q;
        scale_d     = scale_q;
        scale_upd_d = 1'b0;
        peak_out_d  = peak_out_q;

        case (state_q)
            MEASURE: begin
                if (bus.in_valid) begin
                    if (mag > peak_q) peak_d = mag;
                    if (cnt_q == win_len_q) begin
                        cnt_d   = '0;
                        state_d = DECIDE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DECIDE: begin
                target_d = target_calc;
                state_d  = APPLY;
            end
            APPLY: begin
                if (!bus.cfg_manual) begin
                    if (target_q > scale_q) begin
                        scale_d     = target_q;
                        scale_upd_d = 1'b1;
                    end else if (target_q < scale_q) begin
                        scale_d     = scale_q - 1'b1;
                        scale_upd_d = 1'b1;
                    end
                end
                peak_out_d = peak_q;
                peak_d     = '0;
                win_len_d  = bus.cfg_win_len;
                state_d    = MEASURE;
            end
            default: state_d = MEASURE;
        endcase

        // Manual override takes priority every cycle, including APPLY.
        if (bus.cfg_manual) scale_d = manual_scale;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MEASURE;
            peak_q      <= '0;
            cnt_q       <= '0;
            win_len_q   <= bus.cfg_win_len;
            target_q    <= '0;
            scale_q     <= MAX_SCALE;
            scale_upd_q <= 1'b0;
            peak_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            peak_q      <= peak_d;
            cnt_q       <= cnt_d;
            win_len_q   <= win_len_d;
            target_q    <= target_d;
            scale_q     <= scale_d;
            scale_upd_q <= scale_upd_d;
            peak_out_q  <= peak_out_d;
        end
    end

    assign bus.scale     = scale_q;
    assign bus.scale_upd = scale_upd_q;
    assign bus.peak_out  = peak_out_q;

endmodule

// File: tb/tb_scale_agc.sv
// tb_scale_agc: directed bench for scale_agc (IN_WIDTH=16, OUT_WIDTH=4,
// SCALE_WIDTH=4, so the maximum shift is 12). A table of one-sample windows
// exercises the magnitude / bit-length / attack-release path; hand-written
// sequences cover release, attack, gapped valid, manual mode and mid-window reset.
module tb_scale_agc;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    scale_agc_if #(.IN_WIDTH(16), .SCALE_WIDTH(4), .WIN_WIDTH(16)) bus ();

    scale_agc #(
        .IN_WIDTH(16), .OUT_WIDTH(4), .SCALE_WIDTH(4), .WIN_WIDTH(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic signed [15:0] din;
        int                 exp_peak;
        int                 exp_scale;
        int                 exp_upd;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Feeds n back-to-back valid samples (sample at index sp replaced by v2),
    // then idles through DECIDE and APPLY so the caller lands on cycle T+3.
    task automatic window(input int n, input logic signed [15:0] v,
                          input int sp, input logic signed [15:0] v2);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in       = (i == sp) ? v2 : v;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in       = '0;
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        logic [19:0] gap_mask;

        vecs[0]  = '{16'sd32767,  32767, 12, 0};
        vecs[1]  = '{-16'sd32768, 32767, 12, 0};
        vecs[2]  = '{16'sd0,      0,     11, 1};
        vecs[3]  = '{16'sd7,      7,     10, 1};
        vecs[4]  = '{16'sd8,      8,     9,  1};
        vecs[5]  = '{-16'sd1,     0,     8,  1};
        vecs[6]  = '{-16'sd9,     8,     7,  1};
        vecs[7]  = '{16'sd255,    255,   6,  1};
        vecs[8]  = '{16'sd256,    256,   6,  0};
        vecs[9]  = '{-16'sd1024,  1023,  7,  1};
        vecs[10] = '{16'sd1024,   1024,  8,  1};
        vecs[11] = '{16'sd16384,  16384, 12, 1};
        vecs[12] = '{16'sd100,    100,   11, 1};

        reset                = 1'b0;
        bus.in_valid         = 1'b0;
        bus.in               = '0;
        bus.cfg_win_len      = 16'd7;
        bus.cfg_manual       = 1'b0;
        bus.cfg_manual_scale = '0;

        // Reset state
        do_reset();
        chk("reset_scale", bus.scale, 12);
        chk("reset_upd", bus.scale_upd, 0);
        chk("reset_peak", bus.peak_out, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_upd", bus.scale_upd, 0);
        end

        // Release: +1000 -> target 7, one step per window
        for (int k = 0; k < 5; k++) begin
            window(8, 16'sd1000, -1, 16'sd0);
            chk("release_scale", bus.scale, 11 - k);
            chk("release_upd", bus.scale_upd, 1);
            chk("release_peak", bus.peak_out, 1000);
        end
        tick();
        chk("upd_one_cycle", bus.scale_upd, 0);
        for (int k = 0; k < 2; k++) begin
            window(8, 16'sd1000, -1, 16'sd0);
            chk("hold_scale", bus.scale, 7);
            chk("hold_upd", bus.scale_upd, 0);
        end

        // Attack with -32768, then release on zeros down to 0
        window(8, 16'sd0, 3, -16'sd32768);
        chk("attack_peak", bus.peak_out, 32767);
        chk("attack_scale", bus.scale, 12);
        chk("attack_upd", bus.scale_upd, 1);
        for (int k = 0; k < 12; k++) begin
            window(8, 16'sd0, -1, 16'sd0);
            chk("zero_release_scale", bus.scale, 11 - k);
            chk("zero_release_upd", bus.scale_upd, 1);
        end
        window(8, 16'sd0, -1, 16'sd0);
        chk("floor_scale", bus.scale, 0);
        chk("floor_upd", bus.scale_upd, 0);
        chk("floor_peak", bus.peak_out, 0);

        // Gapped valid: 8 valid +100 over 20 cycles, large values while invalid
        gap_mask = 20'h924A5;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = gap_mask[i];
            bus.in       = gap_mask[i] ? 16'sd100 : 16'sd30000;
            tick();
            if (i < 19) chk("gap_no_upd", bus.scale_upd, 0);
        end
        bus.in_valid = 1'b0;
        chk("gap_t1_upd", bus.scale_upd, 0);
        tick();
        chk("gap_t2_upd", bus.scale_upd, 0);
        tick();
        chk("gap_t3_upd", bus.scale_upd, 1);
        chk("gap_scale", bus.scale, 4);
        chk("gap_peak", bus.peak_out, 100);

        // Manual mode
        bus.cfg_manual       = 1'b1;
        bus.cfg_manual_scale = 4'd15;
        tick();
        chk("manual_clamp", bus.scale, 12);
        chk("manual_upd", bus.scale_upd, 0);
        bus.cfg_manual_scale = 4'd3;
        tick();
        chk("manual_3", bus.scale, 3);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in       = 16'sd1000;
            tick();
            chk("manual_win_upd", bus.scale_upd, 0);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("manual_win_upd", bus.scale_upd, 0);
        tick();
        chk("manual_win_upd", bus.scale_upd, 0);
        chk("manual_win_scale", bus.scale, 3);
        chk("manual_win_peak", bus.peak_out, 1000);
        bus.cfg_manual = 1'b0;
        window(8, 16'sd1000, -1, 16'sd0);
        chk("manual_exit_scale", bus.scale, 7);
        chk("manual_exit_upd", bus.scale_upd, 1);

        // Reset mid-window
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in       = 16'sd32000;
            tick();
        end
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_scale", bus.scale, 12);
        chk("midrst_peak", bus.peak_out, 0);
        chk("midrst_upd", bus.scale_upd, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("midrst_idle_upd", bus.scale_upd, 0);
        end
        window(8, 16'sd10, -1, 16'sd0);
        chk("midrst_next_scale", bus.scale, 11);
        chk("midrst_next_upd", bus.scale_upd, 1);
        chk("midrst_next_peak", bus.peak_out, 10);

        // Table of single-sample windows
        bus.cfg_win_len = 16'd0;
        do_reset();
        for (int v = 0; v < 13; v++) begin
            window(1, vecs[v].din, -1, 16'sd0);
            chk($sformatf("vec%0d_peak", v), bus.peak_out, vecs[v].exp_peak);
            chk($sformatf("vec%0d_scale", v), bus.scale, vecs[v].exp_scale);
            chk($sformatf("vec%0d_upd", v), bus.scale_upd, vecs[v].exp_upd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scale_agc.md
# scale_agc

Automatic gain controller for the controlled bit-width reduction stage (`scaler_down`) in the DSP chain.
- Measures the peak magnitude of the wide signed input over a programmable window of valid samples.
- At each window boundary, recomputes the right-shift amount that keeps the reduced output within OUT_WIDTH signed bits.
- Drives the result onto the scaler's `scale` input.
- A manual-override mode lets software force the shift.
- The last window's peak is exposed for monitoring.

## Interface
Parameters:
- IN_WIDTH, 16, width of signed input samples (IN_WIDTH > OUT_WIDTH)
- OUT_WIDTH, 4, width of the scaler's signed output
- SCALE_WIDTH, 4, width of the shift control
- WIN_WIDTH, 16, width of the window-length field

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  `in` carries a sample this cycle
- in  in  IN_WIDTH  signed sample, same signal feeding the scaler
- cfg_win_len  in  WIN_WIDTH  window length minus 1, counted in valid samples
- cfg_manual  in  1  1 = manual shift, 0 = automatic
- cfg_manual_scale  in  SCALE_WIDTH  shift value used in manual mode
- scale  out  SCALE_WIDTH  shift amount to the scaler
- scale_upd  out  1  one-cycle pulse when `scale` changes in auto mode
- peak_out  out  IN_WIDTH-1  peak magnitude of the last completed window

## Operation
- MAX_SHIFT = min(2^SCALE_WIDTH-1, IN_WIDTH-OUT_WIDTH). Every value placed on `scale` is clamped to MAX_SHIFT.
- Magnitude per sample: mag = in[MSB] ? ~in : in, taking the low IN_WIDTH-1 bits.
  - Uses one's complement, so -2^(IN_WIDTH-1) maps to 2^(IN_WIDTH-1)-1 with no overflow.
- The state machine has three states: MEASURE, DECIDE, APPLY.
- MEASURE:
  - For each cycle with in_valid=1: peak <= max(peak, mag) and cnt <= cnt+1.
  - cfg_win_len is latched into win_len when a window starts (on reset and on leaving APPLY).
  - A valid sample arriving with cnt == win_len is the last sample of the window. It is included in peak, cnt is cleared, and the state goes to DECIDE.
  - win_len = 0 gives a window of one sample.
- DECIDE: computes and registers target.
  - bl = bit length of peak (position of the highest set bit plus 1; 0 if peak == 0).
  - target = max(0, bl-(OUT_WIDTH-1)), clamped to MAX_SHIFT.
  - Go to APPLY.
- APPLY, when cfg_manual=0:
  - If target > scale: scale <= target (immediate attack).
  - If target < scale: scale <= scale-1 (release of one step per window).
  - If equal: no change.
  - scale_upd is pulsed only if the value changed.
- APPLY, in all modes: peak_out <= peak, peak is cleared, win_len is re-latched, and the state goes to MEASURE.
- Samples arriving during DECIDE or APPLY are not measured: there is a fixed 2-cycle blind gap per window.
- Manual mode (cfg_manual=1):
  - Each cycle, scale <= min(cfg_manual_scale, MAX_SHIFT).
  - scale_upd stays 0.
  - Window measurement and peak_out continue.
  - On return to auto mode, adaptation starts from the current scale.
- Reset values: scale = MAX_SHIFT (maximum attenuation), scale_upd = 0, peak_out = 0. Internally, peak = 0, cnt = 0, state = MEASURE.
- Reset mid-window discards the partial window; no update is generated.

## Timing
- The last window sample is accepted in cycle T. DECIDE runs in T+1, APPLY in T+2.
- The new `scale`, the scale_upd pulse and the new `peak_out` are visible from cycle T+3. scale_upd is high for exactly cycle T+3.
- Measurement of the next window accepts samples from cycle T+3.
- Manual mode: `scale` follows cfg_manual_scale with 1-cycle latency.
- A cfg_manual transition that coincides with APPLY takes the manual path.
- Reset is asserted in cycle R: all outputs hold their reset values from cycle R+1.
- Minimum window period is win_len+1 valid samples plus 2 cycles.

## Test plan
All scenarios use IN_WIDTH=16, OUT_WIDTH=4, SCALE_WIDTH=4, so MAX_SHIFT=12.
- Reset: pulse reset for 2 cycles -> scale=12, scale_upd=0, peak_out=0; no scale_upd for 20 idle cycles.
- Release: cfg_win_len=7, continuous +1000 samples -> target=7. `scale` steps 11, 10, 9, 8, 7, one step per window with a scale_upd pulse each. It then holds at 7 with no further pulses. peak_out=1000.
- Attack: at scale=7, a window containing one -32768 sample -> peak_out=32767 and scale jumps to 12 at T+3 with a single scale_upd. With samples of 0 afterwards, scale releases by 1 per window down to 0.
- Gapped valid: 8 valid samples of +100 spread over 20 cycles -> exactly one window completes, at the 8th valid sample. scale_upd appears 3 cycles later; samples with in_valid=0 never change peak.
- Manual: cfg_manual=1, cfg_manual_scale=15 -> scale=12 next cycle. Setting cfg_manual_scale=3 -> scale=3; scale_upd stays 0 throughout. Clearing cfg_manual with +1000 input -> the next window ends with scale=7 (attack from 3).
- Reset mid-window: 4 of 8 samples at +32000, then reset -> scale=12, peak_out=0, and no scale_upd. The following window of +10 samples produces a single-step release to 11.
